// File: rtl/sram_march_bist_ctrl_if.sv
// BIST port bundle between the March controller and one 1P SRAM macro.
//   en    BIST select (high while a run is in progress)
//   men   macro enable
//   wen   write enable
//   ren   read enable
//   addr  word address
//   din   write data
//   bm    per-bit write mask (1 = bit written)
//   dout  macro read data back to the controller
// master: the controller side; slave: the macro side.
interface sram_march_bist_ctrl_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    logic              en;
    logic              men;
    logic              wen;
    logic              ren;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] bm;
    logic [DATA_W-1:0] dout;

    modport master (output en, men, wen, ren, addr, din, bm, input dout);
    modport slave  (input en, men, wen, ren, addr, din, bm, output dout);
endinterface

// File: rtl/sram_march_bist_ctrl.sv
// March C- BIST sequencer for a single-port SRAM macro.
// Runs up(w0) up(r0,w1) up(r1,w0) down(r0,w1) down(r1,w0) up(r0) over every
// word, compares read data READ_LAT edges after capture, and records the
// first failing access.
//   clk        single clock, shared with the macro
//   rst_n      synchronous reset, active low
//   start      one-cycle start pulse, accepted in IDLE or DONE
//   abort      stops a run and returns to IDLE
//   busy       run in progress
//   done       run complete, held until the next accepted start
//   fail       sticky mismatch flag for the current run
//   fail_cnt   mismatch count, saturating
//   fail_addr  address of the first mismatch
//   fail_exp   expected word of the first mismatch
//   fail_dout  read data of the first mismatch
//   bist       BIST port towards the macro (master side)
//
// state   | meaning
// S_IDLE  | waiting for start, all BIST pins low
// S_RUN   | issuing March operations, one per cycle
// S_DRAIN | no ops, waiting for the last reads to be compared
// S_DONE  | run finished, results held
module sram_march_bist_ctrl #(
    parameter int                ADDR_W   = 9,
    parameter int                DATA_W   = 32,
    parameter int                READ_LAT = 1,
    parameter logic [DATA_W-1:0] PATTERN  = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    output logic                   busy,
    output logic                   done,
    output logic                   fail,
    output logic [15:0]            fail_cnt,
    output logic [ADDR_W-1:0]      fail_addr,
    output logic [DATA_W-1:0]      fail_exp,
    output logic [DATA_W-1:0]      fail_dout,
    sram_march_bist_ctrl_if.master bist
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_MAX   = '1;
    localparam logic [DATA_W-1:0] D0         = PATTERN;
    localparam logic [DATA_W-1:0] D1         = ~PATTERN;
    localparam logic [1:0]        DRAIN_INIT = 2'(READ_LAT - 1);

    state_t            state, state_d;
    logic [2:0]        elem, elem_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              phase, phase_d;
    logic [1:0]        drain_cnt, drain_d;
    logic              op_d, start_ok, flush;

    logic              two_op, down, at_end, last_op;
    logic              is_wr, wr_one, rd_one;
    logic              men_d, wen_d, ren_d;
    logic [ADDR_W-1:0] pin_addr_d;
    logic [DATA_W-1:0] din_d, bm_d, exp_d;

    logic              men_q, wen_q, ren_q;
    logic [ADDR_W-1:0] pin_addr_q;
    logic [DATA_W-1:0] din_q, bm_q, exp_q;

    // elements 1..4 are read-then-write; 3 and 4 walk the address downwards
    assign two_op  = (elem != 3'd0) && (elem != 3'd5);
    assign down    = (elem == 3'd3) || (elem == 3'd4);
    assign at_end  = down ? (addr_q == '0) : (addr_q == ADDR_MAX);
    assign last_op = (elem == 3'd5) && (addr_q == ADDR_MAX);

    always_comb begin
        state_d  = state;
        elem_d   = elem;
        addr_d   = addr_q;
        phase_d  = phase;
        drain_d  = drain_cnt;
        op_d     = 1'b0;
        start_ok = 1'b0;
        flush    = 1'b0;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (start && !abort) begin
                    state_d  = S_RUN;
                    elem_d   = 3'd0;
                    addr_d   = '0;
                    phase_d  = 1'b0;
                    op_d     = 1'b1;
                    start_ok = 1'b1;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                    flush   = 1'b1;
                end else if (last_op) begin
                    state_d = S_DRAIN;
                    drain_d = DRAIN_INIT;
                end else begin
                    op_d = 1'b1;
                    if (two_op && !phase) begin
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if (at_end) begin
                            // element boundary: reload instead of wrapping
                            elem_d = elem + 3'd1;
                            addr_d = ((elem == 3'd2) || (elem == 3'd3)) ? ADDR_MAX : '0;
                        end else begin
                            addr_d = down ? (addr_q - 1'b1) : (addr_q + 1'b1);
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    state_d = S_IDLE;
                    flush   = 1'b1;
                end else if (drain_cnt == 2'd0) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_cnt - 2'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // pin values for the op presented after the coming edge
    always_comb begin
        is_wr      = (elem_d == 3'd0) || phase_d;
        wr_one     = (elem_d == 3'd1) || (elem_d == 3'd3);
        rd_one     = (elem_d == 3'd2) || (elem_d == 3'd4);
        men_d      = op_d;
        wen_d      = op_d && is_wr;
        ren_d      = op_d && !is_wr;
        pin_addr_d = op_d ? addr_d : '0;
        din_d      = wen_d ? (wr_one ? D1 : D0) : '0;
        bm_d       = wen_d ? '1 : '0;
        exp_d      = rd_one ? D1 : D0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            elem       <= 3'd0;
            addr_q     <= '0;
            phase      <= 1'b0;
            drain_cnt  <= 2'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            men_q      <= 1'b0;
            wen_q      <= 1'b0;
            ren_q      <= 1'b0;
            pin_addr_q <= '0;
            din_q      <= '0;
            bm_q       <= '0;
            exp_q      <= '0;
        end else begin
            state      <= state_d;
            elem       <= elem_d;
            addr_q     <= addr_d;
            phase      <= phase_d;
            drain_cnt  <= drain_d;
            busy       <= (state_d == S_RUN) || (state_d == S_DRAIN);
            done       <= (state_d == S_DONE);
            men_q      <= men_d;
            wen_q      <= wen_d;
            ren_q      <= ren_d;
            pin_addr_q <= pin_addr_d;
            din_q      <= din_d;
            bm_q       <= bm_d;
            exp_q      <= exp_d;
        end
    end

    assign bist.en   = busy;
    assign bist.men  = men_q;
    assign bist.wen  = wen_q;
    assign bist.ren  = ren_q;
    assign bist.addr = pin_addr_q;
    assign bist.din  = din_q;
    assign bist.bm   = bm_q;

    // compare pipe: stage 0 loads at the edge the macro captures the read,
    // the last stage lines up with the edge at which dout is valid
    logic [READ_LAT-1:0] pv;
    logic [ADDR_W-1:0]   pa [READ_LAT];
    logic [DATA_W-1:0]   pe [READ_LAT];
    logic                mismatch;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            pv <= '0;
        end else begin
            pv[0] <= ren_q;
            for (int k = 1; k < READ_LAT; k++) begin
                pv[k] <= pv[k-1];
            end
        end
        pa[0] <= pin_addr_q;
        pe[0] <= exp_q;
        for (int k = 1; k < READ_LAT; k++) begin
            pa[k] <= pa[k-1];
            pe[k] <= pe[k-1];
        end
    end

    assign mismatch = pv[READ_LAT-1] && !flush && (bist.dout != pe[READ_LAT-1]);

    always_ff @(posedge clk) begin
        if (!rst_n || start_ok) begin
            fail      <= 1'b0;
            fail_cnt  <= 16'd0;
            fail_addr <= '0;
            fail_exp  <= '0;
            fail_dout <= '0;
        end else if (mismatch) begin
            fail <= 1'b1;
            if (fail_cnt != 16'hFFFF) begin
                fail_cnt <= fail_cnt + 16'd1;
            end
            if (!fail) begin
                fail_addr <= pa[READ_LAT-1];
                fail_exp  <= pe[READ_LAT-1];
                fail_dout <= bist.dout;
            end
        end
    end

endmodule
